// File: rtl/stepper_seq_ctrl.sv
// Stepper-motor sequencer for one 4-wire H-bridge: accepts move commands,
// walks the 8-entry coil phase table at a programmable rate and tracks absolute position.
//
// state | meaning
// IDLE  | waiting for a command; coils coast or hold the last phase
// RUN   | stepping until steps_left reaches zero or abort
module stepper_seq_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DIV_W        = 16,
    parameter int HALF_STEP_EN = 1,
    parameter int HOLD_EN      = 0
) (
    input  logic             clk,
    input  logic             PRESERN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             cmd_half,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    input  logic             pos_clear,
    output logic [3:0]       hb_state,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left,
    output logic [CNT_W-1:0] position
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_idx;
    logic             r_energised;
    logic             r_dir;
    logic             r_half;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_tick;
    logic [CNT_W-1:0] r_steps_left;
    logic [CNT_W-1:0] r_position;
    logic [3:0]       r_hb;
    logic             r_done;
    logic             r_aborted;
    logic             r_busy;

    logic             w_accept;
    logic             w_step;
    logic             w_abort_now;
    logic             w_last;
    logic             w_cmd_zero;
    logic             w_half_req;
    logic [2:0]       w_inc;
    logic [2:0]       w_idx_nxt;
    logic [CNT_W-1:0] w_pos_delta;

    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        case (idx)
            3'd0:    phase_of = 4'b1001;
            3'd1:    phase_of = 4'b0001;
            3'd2:    phase_of = 4'b0101;
            3'd3:    phase_of = 4'b0100;
            3'd4:    phase_of = 4'b0110;
            3'd5:    phase_of = 4'b0010;
            3'd6:    phase_of = 4'b1010;
            default: phase_of = 4'b1000;
        endcase
    endfunction

    assign w_cmd_zero  = (cmd_steps == '0);
    assign w_half_req  = (HALF_STEP_EN != 0) ? cmd_half : 1'b0;
    assign w_inc       = r_half ? 3'd1 : 3'd2;
    assign w_idx_nxt   = r_dir ? (r_idx + w_inc) : (r_idx - w_inc);
    assign w_pos_delta = {{(CNT_W-2){1'b0}}, (r_half ? 2'd1 : 2'd2)};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_abort_now = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (!w_cmd_zero) w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort beats a step falling due on the same edge
                if (abort) begin
                    w_abort_now = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tick == '0) begin
                    w_step = 1'b1;
                    if (r_steps_left == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge PRESERN) begin
        if (!PRESERN) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge PRESERN) begin
        if (!PRESERN) begin
            r_idx        <= '0;
            r_energised  <= 1'b0;
            r_dir        <= 1'b0;
            r_half       <= 1'b0;
            r_div        <= '0;
            r_tick       <= '0;
            r_steps_left <= '0;
            r_position   <= '0;
            r_hb         <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_done <= w_last | w_abort_now | (w_accept & w_cmd_zero);
            r_busy <= (w_state_nxt == ST_RUN);

            if (w_accept) begin
                r_aborted <= 1'b0;
                if (!w_cmd_zero) begin
                    r_dir        <= cmd_dir;
                    r_half       <= w_half_req;
                    r_div        <= cmd_div;
                    r_tick       <= cmd_div;
                    r_steps_left <= cmd_steps;
                end
            end
            if (w_abort_now) r_aborted <= 1'b1;

            if (r_state == ST_RUN && !w_abort_now) begin
                if (w_step) begin
                    r_tick       <= r_div;
                    r_idx        <= w_idx_nxt;
                    r_steps_left <= r_steps_left - 1'b1;
                    r_energised  <= 1'b1;
                    r_hb         <= phase_of(w_idx_nxt);
                end else begin
                    r_tick <= r_tick - 1'b1;
                end
            end

            if (r_state == ST_IDLE)
                r_hb <= ((HOLD_EN != 0) && r_energised) ? phase_of(r_idx) : 4'b0000;

            if (pos_clear)   r_position <= '0;
            else if (w_step) r_position <= r_dir ? (r_position + w_pos_delta)
                                                 : (r_position - w_pos_delta);
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign hb_state   = r_hb;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign steps_left = r_steps_left;
    assign position   = r_position;

endmodule

// File: doc/stepper_seq_ctrl.md
Name: stepper_seq_ctrl

Overview:
- Parametrised stepper-motor sequencer driving one 4-wire H-bridge.
- Accepts move commands over a valid/ready handshake: step count, direction, full/half-step mode and per-move step-rate divider.
- Sequences the coil phases, tracks absolute position, and supports abort and optional holding torque.
- Sits between the bus-side command registers and the H-bridge pins.

Parameters:
- CNT_W, 32: width of step count, steps_left and position.
- DIV_W, 16: width of the step-rate divider.
- HALF_STEP_EN, 1: 1 enables half-step mode; 0 forces cmd_half to be treated as 0.
- HOLD_EN, 0: 1 keeps the last phase energised while idle; 0 coasts (0000) while idle.

Ports:
- clk  in  1  system clock, rising edge.
- PRESERN  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high exactly when the state is IDLE.
- cmd_steps  in  CNT_W  number of steps to take (unsigned).
- cmd_dir  in  1  1 = forward, 0 = reverse.
- cmd_half  in  1  1 = half-step mode, 0 = full-step mode.
- cmd_div  in  DIV_W  step period = cmd_div+1 clocks.
- abort  in  1  stop the current move.
- pos_clear  in  1  zero the position counter.
- hb_state  out  4  H-bridge drive pattern (registered).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at the end of a move, abort, or zero-step command.
- aborted  out  1  sticky; set by abort, cleared on the next accepted command.
- steps_left  out  CNT_W  remaining steps.
- position  out  CNT_W  signed absolute position in half-step units.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; cmd_ready=1.
  - hb_state=0000; busy=0; done=0; aborted=0; steps_left=0; position=0.
  - Phase index idx=0; energised flag=0.
- Phase table, idx 0..7: 1001, 0001, 0101, 0100, 0110, 0010, 1010, 1000.
- Step rules:
  - Forward adds inc to idx; reverse subtracts inc. idx wraps mod 8.
  - inc = 2 in full-step mode, 1 in half-step mode.
  - Full-step from an odd idx keeps its parity (wave drive).
- idx persists across moves and is never reset except by PRESERN.
- Position update on each step:
  - Forward: position += inc. Reverse: position -= inc.
  - Two's-complement wrap, no saturation.
- IDLE:
  - hb_state = table[idx] if HOLD_EN=1 and energised=1; otherwise 0000.
  - On cmd_valid&cmd_ready with cmd_steps=0: done pulses the next cycle, state stays IDLE, aborted is cleared, no motion.
  - On cmd_valid&cmd_ready with cmd_steps>0:
    - Latch dir, mode and div.
    - steps_left <= cmd_steps; tick <= cmd_div; aborted <= 0; go to RUN.
- RUN (busy=1, cmd_ready=0):
  - Each cycle: if tick=0, take a step and reload tick <= div; otherwise tick--.
  - A step updates idx, hb_state <= table[new idx], steps_left--, position, and sets energised=1.
  - With the accepting edge as E0, step k (1..N) occurs on edge E0+k*(div+1).
  - cmd_div=0 gives one step per clock.
  - On the edge that takes the last step (steps_left 1->0): go to IDLE and pulse done the following cycle.
  - hb_state holds the final pattern if HOLD_EN=1, else returns to 0000 on the next edge.
- abort:
  - In RUN: on the next edge go to IDLE, set aborted=1 and pulse done.
  - Takes priority over a step due on the same edge (no step taken).
  - steps_left retains the untaken count.
  - Ignored in IDLE.
- pos_clear:
  - position <= 0 in any state.
  - Wins over a simultaneous step update; idx is unaffected.
- cmd_valid while busy: not accepted (cmd_ready=0); the command must be held by the source.
- Outputs are all registered except cmd_ready, which is decoded from the state register.
- PRESERN asserted mid-move: immediate reset values, hb_state=0000 with no clock required.

Test Plan:
- Reset, then forward full-step, steps=3, div=1 -> hb_state 0101@E0+2, 0110@E0+4, 1010@E0+6. done pulses once. position=6, idx=6, steps_left=0, then hb_state=0000 (HOLD_EN=0).
- Reverse half-step, steps=9, div=0 from idx=0 -> patterns 1000, 1010, 0010, 0110, 0100, 0101, 0001, 1001, 1000 on consecutive edges. position=-9, idx wraps to 7.
- steps=5, div=3, abort asserted 1 cycle before the 3rd step edge -> only 2 steps taken, steps_left=3, aborted=1, done pulses once. The next accepted command clears aborted.
- cmd_steps=0 -> done pulse, busy never asserts, hb_state and position unchanged. cmd_valid during RUN -> not accepted until cmd_ready returns.
- HOLD_EN=1: after a move ending at idx=2, hb_state stays 0101 in IDLE. After reset it is 0000 until the first step. pos_clear coincident with a step -> position=0 while idx advances.
- PRESERN low mid-move with clk stopped -> hb_state=0000, busy=0, position=0 immediately. After release, cmd_ready=1.
